// File: rtl/dn_write_pacer_if.sv
// rtl/dn_write_pacer_if.sv - host loader and downstream write signals of dn_write_pacer
//
// Purpose: bundles the host download port (ioctl_*), the write-slot enable
// ce_2 and the downstream system write port (dn_*) into one interface.
// Modports:
//   master - host/system side: drives ce_2 and ioctl_*, observes ioctl_wait and dn_*
//   slave  - pacer side: observes ce_2 and ioctl_*, drives ioctl_wait and dn_*
interface dn_write_pacer_if;
    logic        ce_2;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic        ioctl_wait;
    logic [16:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic [7:0]  dn_index;
    logic        dn_busy;
    logic [16:0] dn_count;
    logic        dn_error;

    modport master (
        output ce_2, ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        input  ioctl_wait, dn_addr, dn_data, dn_wr, dn_index, dn_busy, dn_count, dn_error
    );

    modport slave (
        input  ce_2, ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        output ioctl_wait, dn_addr, dn_data, dn_wr, dn_index, dn_busy, dn_count, dn_error
    );
endinterface

// File: rtl/dn_write_pacer.sv
// rtl/dn_write_pacer.sv - paces host download bytes into one-per-slot system writes
//
// Purpose: queues bytes from the host loader in a small FIFO and replays them
// as one-cycle system writes, at most one per ce_2 slot. Keeps dn_busy high
// while loading, while draining and for HOLD_CYCLES cycles afterwards.
// Ports:
//   clk_sys - sole clock, rising edge
//   reset   - asynchronous, active-high
//   bus     - dn_write_pacer_if.slave: ce_2, ioctl_* in; ioctl_wait, dn_* out
// Parameters:
//   DEPTH       - FIFO entries, power of two, >= 2
//   HOLD_CYCLES - cycles dn_busy stays high after the FIFO drains, >= 1
module dn_write_pacer #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    dn_write_pacer_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_HIWAT = (AW+1)'(DEPTH - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_HOLD
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [24:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic [HW-1:0] hold_q;

    logic          dl_q;
    logic          wait_q;
    logic          dn_wr_q;
    logic [16:0]   dn_addr_q;
    logic [7:0]    dn_data_q;
    logic [7:0]    dn_index_q;
    logic [16:0]   dn_count_q;
    logic          dn_error_q;

    logic dl_rise;
    logic push_req;
    logic addr_bad;
    logic fifo_full;
    logic push;
    logic drop;
    logic pop;
    logic wait_d;

    // A new download may start from any state; it re-latches the index and
    // restarts the per-download statistics but keeps anything still queued.
    assign dl_rise   = bus.ioctl_download & ~dl_q;
    assign push_req  = bus.ioctl_wr & bus.ioctl_download;
    assign addr_bad  = |bus.ioctl_addr[24:17];
    assign fifo_full = (count_q == CNT_FULL);
    assign push      = push_req & ~addr_bad & ~fifo_full;
    assign drop      = push_req & (addr_bad | fifo_full);
    assign pop       = bus.ce_2 & (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (dl_rise) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (!bus.ioctl_download) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // An empty FIFO means no pop can be issued this cycle, so the
                // last write (if any) is already on dn_wr and hold can start.
                if (dl_rise)              state_d = ST_LOAD;
                else if (count_q == '0)   state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (dl_rise)                state_d = ST_LOAD;
                else if (hold_q == HOLD_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Back-pressure is computed from next-cycle occupancy and state so the
    // registered flag lines up with the FIFO and FSM it describes.
    assign wait_d = (count_d >= CNT_HIWAT) || (state_d == ST_DRAIN) || (state_d == ST_HOLD);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem[wr_ptr_q] <= {bus.ioctl_addr[16:0], bus.ioctl_dout};
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_q       <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            hold_q     <= '0;
            wait_q     <= 1'b0;
            dn_wr_q    <= 1'b0;
            dn_addr_q  <= '0;
            dn_data_q  <= '0;
            dn_index_q <= '0;
            dn_count_q <= '0;
            dn_error_q <= 1'b0;
        end else begin
            dl_q    <= bus.ioctl_download;
            count_q <= count_d;
            wait_q  <= wait_d;
            dn_wr_q <= pop;

            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;

            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                dn_addr_q <= mem[rd_ptr_q][24:8];
                dn_data_q <= mem[rd_ptr_q][7:0];
            end

            if (state_q == ST_HOLD && state_d == ST_HOLD) hold_q <= hold_q + 1'b1;
            else                                          hold_q <= '0;

            if (dl_rise) dn_index_q <= bus.ioctl_index;

            // The count tracks dn_wr as it becomes visible; a pop in the
            // start cycle belongs to the new download.
            if (dl_rise)                               dn_count_q <= {16'b0, pop};
            else if (pop && dn_count_q != 17'h1FFFF)   dn_count_q <= dn_count_q + 17'd1;

            // A drop in the start cycle is a byte of the new download, so it
            // must survive the clear.
            dn_error_q <= (dn_error_q & ~dl_rise) | drop;
        end
    end

    assign bus.ioctl_wait = wait_q;
    assign bus.dn_wr      = dn_wr_q;
    assign bus.dn_addr    = dn_addr_q;
    assign bus.dn_data    = dn_data_q;
    assign bus.dn_index   = dn_index_q;
    assign bus.dn_count   = dn_count_q;
    assign bus.dn_error   = dn_error_q;
    assign bus.dn_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dn_write_pacer.sv
// tb/tb_dn_write_pacer.sv - scoreboard bench for dn_write_pacer
module tb_dn_write_pacer;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;

    always #5 clk_sys = ~clk_sys;

    dn_write_pacer_if bus ();

    dn_write_pacer #(
        .DEPTH       (4),
        .HOLD_CYCLES (16)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    typedef struct {
        logic [16:0] addr;
        logic [7:0]  data;
        logic [7:0]  idx;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    int          wr_total  = 0;
    int          exp_count = 0;
    int          last_lat  = 0;
    logic [7:0]  cur_idx   = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (!reset && bus.dn_wr === 1'b1) begin
            wr_total++;
            exp_count++;
            check_eq("wr_has_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e    = sb.pop_front();
                last_lat = cyc - mon_e.cyc;
                check_eq("wr_addr", 32'(bus.dn_addr), 32'(mon_e.addr));
                check_eq("wr_data", 32'(bus.dn_data), 32'(mon_e.data));
                check_eq("wr_index", 32'(bus.dn_index), 32'(mon_e.idx));
            end
            check_eq("wr_count", 32'(bus.dn_count), 32'(exp_count));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic push_byte(input logic [24:0] addr, input logic [7:0] data, input bit accept);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = addr;
        bus.ioctl_dout = data;
        if (accept) sb.push_back('{addr[16:0], data, cur_idx, cyc});
        @(posedge clk_sys);
        #1;
        bus.ioctl_wr = 1'b0;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        cur_idx            = idx;
        exp_count          = 0;
        bus.ioctl_index    = idx;
        bus.ioctl_download = 1'b1;
        step(1);
    endtask

    task automatic wait_writes(input int target, input int budget, input string tag);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_sys);
            #1;
            if (wr_total >= target) begin
                done = 1'b1;
                break;
            end
        end
        check_eq(tag, 32'(done), 32'd1);
    endtask

    task automatic end_dl(input string tag);
        bit done = 1'b0;
        bus.ioctl_download = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_sys);
            #1;
            if (bus.dn_busy === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        check_eq(tag, 32'(done), 32'd1);
    endtask

    task automatic check_zero(input string pfx);
        check_eq({pfx, "_wait"},  32'(bus.ioctl_wait), 32'd0);
        check_eq({pfx, "_wr"},    32'(bus.dn_wr),      32'd0);
        check_eq({pfx, "_busy"},  32'(bus.dn_busy),    32'd0);
        check_eq({pfx, "_error"}, 32'(bus.dn_error),   32'd0);
        check_eq({pfx, "_addr"},  32'(bus.dn_addr),    32'd0);
        check_eq({pfx, "_data"},  32'(bus.dn_data),    32'd0);
        check_eq({pfx, "_index"}, 32'(bus.dn_index),   32'd0);
        check_eq({pfx, "_count"}, 32'(bus.dn_count),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int  base;
        bit  done;
        bit  busy_ok;

        bus.ce_2           = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        bus.ioctl_index    = '0;

        repeat (3) @(negedge clk_sys);
        check_zero("reset");
        step(1);
        reset = 1'b0;
        step(2);

        // Single byte with every slot enabled: write lands two cycles later.
        bus.ce_2 = 1'b1;
        start_dl(8'h01);
        check_eq("load_busy", 32'(bus.dn_busy), 32'd1);
        base = wr_total;
        push_byte(25'h0_0010, 8'hA5, 1'b1);
        wait_writes(base + 1, 20, "single_wr_seen");
        check_eq("single_latency", 32'(last_lat), 32'd2);
        end_dl("single_idle");

        // Back-pressure: third entry raises wait, draining releases it.
        bus.ce_2 = 1'b0;
        start_dl(8'h02);
        check_eq("hold_addr", 32'(bus.dn_addr), 32'h10);
        check_eq("hold_data", 32'(bus.dn_data), 32'hA5);
        base = wr_total;
        push_byte(25'h0_0200, 8'h01, 1'b1);
        push_byte(25'h0_0201, 8'h02, 1'b1);
        check_eq("bp_wait_at_2", 32'(bus.ioctl_wait), 32'd0);
        push_byte(25'h0_0202, 8'h03, 1'b1);
        check_eq("bp_wait_at_3", 32'(bus.ioctl_wait), 32'd1);
        check_eq("bp_no_wr_yet", 32'(wr_total - base), 32'd0);
        bus.ce_2 = 1'b1;
        wait_writes(base + 3, 30, "bp_three_wr");
        step(2);
        check_eq("bp_wait_released", 32'(bus.ioctl_wait), 32'd0);
        end_dl("bp_idle");

        // Overrun: fifth push into a full FIFO is lost and flagged.
        bus.ce_2 = 1'b0;
        start_dl(8'h03);
        base = wr_total;
        for (int i = 0; i < 5; i++) begin
            push_byte(25'(12'h300 + i), 8'(8'h40 + i), i < 4);
        end
        check_eq("ovr_error", 32'(bus.dn_error), 32'd1);
        check_eq("ovr_wait", 32'(bus.ioctl_wait), 32'd1);
        bus.ce_2 = 1'b1;
        wait_writes(base + 4, 40, "ovr_four_wr");
        step(10);
        check_eq("ovr_wr_total", 32'(wr_total - base), 32'd4);
        check_eq("ovr_sb_empty", 32'(sb.size()), 32'd0);
        end_dl("ovr_idle");

        // Out-of-range address dropped; top legal address passes.
        bus.ce_2 = 1'b1;
        start_dl(8'h04);
        check_eq("oor_error_cleared", 32'(bus.dn_error), 32'd0);
        check_eq("oor_count_cleared", 32'(bus.dn_count), 32'd0);
        base = wr_total;
        push_byte(25'h002_0000, 8'h11, 1'b0);
        push_byte(25'h001_FFFF, 8'h22, 1'b1);
        wait_writes(base + 1, 20, "oor_wr_seen");
        step(5);
        check_eq("oor_error", 32'(bus.dn_error), 32'd1);
        check_eq("oor_wr_total", 32'(wr_total - base), 32'd1);
        end_dl("oor_idle");

        // Drain and hold with sparse write slots.
        bus.ce_2 = 1'b0;
        start_dl(8'h05);
        base = wr_total;
        push_byte(25'h0_0100, 8'h5A, 1'b1);
        push_byte(25'h0_0101, 8'hC3, 1'b1);
        bus.ioctl_download = 1'b0;
        step(2);
        check_eq("drain_busy", 32'(bus.dn_busy), 32'd1);
        check_eq("drain_wait", 32'(bus.ioctl_wait), 32'd1);
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk_sys);
            #1;
            bus.ce_2 = (i % 12 == 0);
            @(negedge clk_sys);
            #1;
            if (wr_total >= base + 2) begin
                done = 1'b1;
                break;
            end
        end
        bus.ce_2 = 1'b0;
        check_eq("drain_two_wr", 32'(done), 32'd1);
        busy_ok = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk_sys);
            if (bus.dn_busy !== 1'b1) busy_ok = 1'b0;
        end
        check_eq("hold_busy_16", 32'(busy_ok), 32'd1);
        @(negedge clk_sys);
        check_eq("hold_to_idle", 32'(bus.dn_busy), 32'd0);
        check_eq("idle_wait", 32'(bus.ioctl_wait), 32'd0);

        // Strobe outside a download window is ignored.
        step(1);
        base = wr_total;
        bus.ce_2 = 1'b1;
        push_byte(25'h002_0000, 8'h77, 1'b0);
        push_byte(25'h0_0005, 8'h78, 1'b0);
        step(6);
        check_eq("nodl_error", 32'(bus.dn_error), 32'd0);
        check_eq("nodl_no_wr", 32'(wr_total - base), 32'd0);
        check_eq("nodl_idle", 32'(bus.dn_busy), 32'd0);

        // Reset abort with three entries queued.
        bus.ce_2 = 1'b0;
        start_dl(8'h06);
        push_byte(25'h0_0400, 8'h81, 1'b1);
        push_byte(25'h0_0401, 8'h82, 1'b1);
        push_byte(25'h0_0402, 8'h83, 1'b1);
        reset = 1'b1;
        #1;
        check_zero("abort");
        sb.delete();
        bus.ioctl_download = 1'b0;
        step(2);
        reset = 1'b0;
        bus.ce_2 = 1'b1;
        base = wr_total;
        step(30);
        check_eq("abort_no_wr", 32'(wr_total - base), 32'd0);
        check_eq("abort_idle", 32'(bus.dn_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
